// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: one outstanding imem request, a hold buffer for words
// that arrive while decode stalls, and a discard state for redirects that race a pending fetch.
module if_fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] BUBBLE   = 32'h8000_0000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] if_ir,
   output logic [31:0] if_npc,
   output logic        if_valid,
   output logic [15:0] fetch_count,
   output logic [1:0]  o_dbg_state
);

   // Handshake: imem_req is high in REQ and DISCARD with imem_addr = pc; both stay
   // stable until imem_ack is seen on a rising edge, which completes that request.
   typedef enum logic [1:0] {
      ST_REQ     = 2'd0,
      ST_HOLD    = 2'd1,
      ST_DISCARD = 2'd2
   } state_t;

   state_t      r_state;
   logic [31:0] r_pc;
   logic [31:0] r_buf;
   logic [31:0] r_target;
   logic [31:0] r_ir;
   logic [31:0] r_npc;
   logic        r_valid;
   logic [15:0] r_count;
   logic [31:0] w_pc_plus4;

   assign w_pc_plus4 = r_pc + 32'd4;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state  <= ST_REQ;
         r_pc     <= RESET_PC;
         r_buf    <= 32'd0;
         r_target <= 32'd0;
         r_ir     <= BUBBLE;
         r_npc    <= 32'd0;
         r_valid  <= 1'b0;
         r_count  <= 16'd0;
      end else begin
         case (r_state)
            ST_REQ: begin
               if (redirect) begin
                  r_ir    <= BUBBLE;
                  r_valid <= 1'b0;
                  r_buf   <= 32'd0;
                  if (imem_ack) begin
                     r_pc <= redirect_pc;
                  end else begin
                     // The in-flight fetch must still complete before the new target is requested.
                     r_target <= redirect_pc;
                     r_state  <= ST_DISCARD;
                  end
               end else if (stall) begin
                  if (imem_ack) begin
                     r_buf   <= imem_rdata;
                     r_state <= ST_HOLD;
                  end
               end else if (imem_ack) begin
                  r_ir    <= imem_rdata;
                  r_npc   <= w_pc_plus4;
                  r_valid <= 1'b1;
                  r_pc    <= w_pc_plus4;
                  r_count <= r_count + 16'd1;
               end else begin
                  r_ir    <= BUBBLE;
                  r_valid <= 1'b0;
               end
            end

            ST_HOLD: begin
               if (redirect) begin
                  r_ir    <= BUBBLE;
                  r_valid <= 1'b0;
                  r_buf   <= 32'd0;
                  r_pc    <= redirect_pc;
                  r_state <= ST_REQ;
               end else if (!stall) begin
                  r_ir    <= r_buf;
                  r_npc   <= w_pc_plus4;
                  r_valid <= 1'b1;
                  r_pc    <= w_pc_plus4;
                  r_count <= r_count + 16'd1;
                  r_state <= ST_REQ;
               end
            end

            ST_DISCARD: begin
               if (redirect) begin
                  r_ir    <= BUBBLE;
                  r_valid <= 1'b0;
                  if (imem_ack) begin
                     r_pc    <= redirect_pc;
                     r_state <= ST_REQ;
                  end else begin
                     r_target <= redirect_pc;
                  end
               end else begin
                  if (!stall) begin
                     r_ir    <= BUBBLE;
                     r_valid <= 1'b0;
                  end
                  if (imem_ack) begin
                     r_pc    <= r_target;
                     r_state <= ST_REQ;
                  end
               end
            end

            default: r_state <= ST_REQ;
         endcase
      end
   end

   // Request is gated by reset so nothing is issued while the stage is held in reset.
   assign imem_req    = (r_state != ST_HOLD) && !reset;
   assign imem_addr   = r_pc;
   assign if_ir       = r_ir;
   assign if_npc      = r_npc;
   assign if_valid    = r_valid;
   assign fetch_count = r_count;
   assign o_dbg_state = r_state;

endmodule
